// File: rtl/scaler_read_if.sv
// Bus between the scaler read-side sequencer and its neighbours (FIFO read
// ports on one side, interpolation datapath on the other).
//
// Handshake: a pixel transfers on a clk edge where outputValid && outputReady
// are both high. While outputValid is high and outputReady is low, every pixel
// output (addresses, blends, bottomEdge) holds stable. outputValid never drops
// without a transfer. advanceRead1/advanceRead2/frameDone are unacknowledged
// single-cycle pulses.
//
// master: the controller (drives addresses, blends, pulses, status)
// slave : the environment (drives start, resolutions, scales, fillCount,
//         outputReady)
interface scaler_read_if #(
  parameter int ADDRESS_WIDTH     = 11,
  parameter int BUFFER_SIZE_WIDTH = 3,
  parameter int FRAC_BITS         = 14,
  parameter int COEFF_WIDTH       = 8
);
  logic                               start;
  logic [ADDRESS_WIDTH-1:0]           inputXRes;
  logic [ADDRESS_WIDTH-1:0]           inputYRes;
  logic [ADDRESS_WIDTH-1:0]           outputXRes;
  logic [ADDRESS_WIDTH-1:0]           outputYRes;
  logic [ADDRESS_WIDTH+FRAC_BITS-1:0] xScale;
  logic [ADDRESS_WIDTH+FRAC_BITS-1:0] yScale;
  logic [BUFFER_SIZE_WIDTH-1:0]       fillCount;
  logic                               outputReady;

  logic [ADDRESS_WIDTH-1:0]           readAddress00;
  logic [ADDRESS_WIDTH-1:0]           readAddress01;
  logic [ADDRESS_WIDTH-1:0]           readAddress10;
  logic [ADDRESS_WIDTH-1:0]           readAddress11;
  logic [COEFF_WIDTH-1:0]             xBlend;
  logic [COEFF_WIDTH-1:0]             yBlend;
  logic                               bottomEdge;
  logic                               outputValid;
  logic                               advanceRead1;
  logic                               advanceRead2;
  logic                               busy;
  logic                               frameDone;

  modport master (
    input  start, inputXRes, inputYRes, outputXRes, outputYRes,
           xScale, yScale, fillCount, outputReady,
    output readAddress00, readAddress01, readAddress10, readAddress11,
           xBlend, yBlend, bottomEdge, outputValid,
           advanceRead1, advanceRead2, busy, frameDone
  );

  modport slave (
    output start, inputXRes, inputYRes, outputXRes, outputYRes,
           xScale, yScale, fillCount, outputReady,
    input  readAddress00, readAddress01, readAddress10, readAddress11,
           xBlend, yBlend, bottomEdge, outputValid,
           advanceRead1, advanceRead2, busy, frameDone
  );
endinterface

// File: rtl/scaler_read_ctrl.sv
// Read-side sequencer for the scaler line-buffer FIFO (4 line RAMs).
// For every output pixel it presents the 2x2 bilinear neighbourhood column
// addresses (deepest line and second line) plus fixed-point blend weights,
// and retires consumed input lines with advanceRead1/advanceRead2 pulses.
//
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   bus       : scaler_read_if.master (config, fillCount, pixel handshake,
//               advance pulses, busy/frameDone)
//   state_dbg : current FSM state encoding, for observation only
//
// COEFF_WIDTH must not exceed FRAC_BITS (blends are the top fraction bits).
module scaler_read_ctrl #(
  parameter int ADDRESS_WIDTH     = 11,
  parameter int BUFFER_SIZE_WIDTH = 3,
  parameter int FRAC_BITS         = 14,
  parameter int COEFF_WIDTH       = 8
) (
  input  logic          clk,
  input  logic          rst,
  scaler_read_if.master bus,
  output logic [2:0]    state_dbg
);
  localparam int PW = ADDRESS_WIDTH + FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RUN, S_LINE_END, S_GAP, S_DRAIN, S_DRAIN_GAP
  } state_t;

  state_t                   state;
  logic [PW-1:0]            x_pos;
  logic [PW-1:0]            y_pos;
  logic [ADDRESS_WIDTH-1:0] out_x;
  logic [ADDRESS_WIDTH-1:0] out_y;
  // One bit wider so it can reach inputYRes+1 at the largest resolution.
  logic [ADDRESS_WIDTH:0]   lines_consumed;

  logic [PW-1:0]            x_next;
  logic [PW-1:0]            y_next;
  logic [ADDRESS_WIDTH-1:0] y_int;
  logic [ADDRESS_WIDTH-1:0] y_step;
  logic [1:0]               delta;
  logic                     at_bottom;
  logic                     fill_ok;
  logic [PW-1:0]            pix_pos;
  logic [ADDRESS_WIDTH-1:0] pix_int;
  logic [ADDRESS_WIDTH-1:0] pix_a0;
  logic [ADDRESS_WIDTH-1:0] pix_a1;
  logic [COEFF_WIDTH-1:0]   pix_blend;
  logic                     unused_bits;

  assign x_next    = x_pos + bus.xScale;
  assign y_next    = y_pos + bus.yScale;
  assign y_int     = y_pos[PW-1:FRAC_BITS];
  // Lines crossed by the next vertical step; steps beyond 2 are clamped and
  // the skipped lines are left in the FIFO.
  assign y_step    = y_next[PW-1:FRAC_BITS] - y_int;
  assign delta     = (y_step >= ADDRESS_WIDTH'(2)) ? 2'd2 : y_step[1:0];
  assign at_bottom = (y_int == bus.inputYRes);
  // The last input line pairs with itself, so it only needs one filled line.
  assign fill_ok   = at_bottom ? (bus.fillCount >= BUFFER_SIZE_WIDTH'(1))
                               : (bus.fillCount >= BUFFER_SIZE_WIDTH'(2));

  // Position of the pixel about to be loaded into the output registers:
  // column 0 when a line starts from WAIT, the next step while in RUN.
  assign pix_pos   = (state == S_RUN) ? x_next : '0;
  assign pix_int   = pix_pos[PW-1:FRAC_BITS];
  assign pix_a0    = (pix_int > bus.inputXRes) ? bus.inputXRes : pix_int;
  assign pix_a1    = (pix_a0 < bus.inputXRes) ? pix_a0 + ADDRESS_WIDTH'(1)
                                              : bus.inputXRes;
  assign pix_blend = pix_pos[FRAC_BITS-1 -: COEFF_WIDTH];
  assign unused_bits = ^{pix_pos, y_pos};

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      x_pos             <= '0;
      y_pos             <= '0;
      out_x             <= '0;
      out_y             <= '0;
      lines_consumed    <= '0;
      bus.readAddress00 <= '0;
      bus.readAddress01 <= '0;
      bus.readAddress10 <= '0;
      bus.readAddress11 <= '0;
      bus.xBlend        <= '0;
      bus.yBlend        <= '0;
      bus.bottomEdge    <= 1'b0;
      bus.outputValid   <= 1'b0;
      bus.advanceRead1  <= 1'b0;
      bus.advanceRead2  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.frameDone     <= 1'b0;
    end else begin
      // Pulses are high for exactly the one cycle after they are set.
      bus.advanceRead1 <= 1'b0;
      bus.advanceRead2 <= 1'b0;
      bus.frameDone    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_pos          <= '0;
            y_pos          <= '0;
            out_x          <= '0;
            out_y          <= '0;
            lines_consumed <= '0;
            bus.busy       <= 1'b1;
            state          <= S_WAIT;
          end
        end

        S_WAIT: begin
          bus.bottomEdge <= at_bottom;
          if (fill_ok) begin
            x_pos             <= '0;
            out_x             <= '0;
            bus.readAddress00 <= pix_a0;
            bus.readAddress10 <= pix_a0;
            bus.readAddress01 <= pix_a1;
            bus.readAddress11 <= pix_a1;
            bus.xBlend        <= pix_blend;
            bus.yBlend        <= y_pos[FRAC_BITS-1 -: COEFF_WIDTH];
            bus.outputValid   <= 1'b1;
            state             <= S_RUN;
          end
        end

        S_RUN: begin
          if (bus.outputReady) begin
            x_pos <= x_next;
            out_x <= out_x + ADDRESS_WIDTH'(1);
            if (out_x == bus.outputXRes) begin
              bus.outputValid <= 1'b0;
              state           <= S_LINE_END;
            end else begin
              bus.readAddress00 <= pix_a0;
              bus.readAddress10 <= pix_a0;
              bus.readAddress01 <= pix_a1;
              bus.readAddress11 <= pix_a1;
              bus.xBlend        <= pix_blend;
            end
          end
        end

        S_LINE_END: begin
          if (out_y == bus.outputYRes) begin
            state <= S_DRAIN;
          end else begin
            bus.advanceRead1 <= (delta == 2'd1);
            bus.advanceRead2 <= (delta == 2'd2);
            lines_consumed   <= lines_consumed + (ADDRESS_WIDTH + 1)'(delta);
            y_pos            <= y_next;
            out_y            <= out_y + ADDRESS_WIDTH'(1);
            state            <= S_GAP;
          end
        end

        S_GAP: state <= S_WAIT;

        S_DRAIN: begin
          // >= rather than == so an over-retired count cannot stall the drain.
          if (lines_consumed >= {1'b0, bus.inputYRes} + (ADDRESS_WIDTH + 1)'(1)) begin
            bus.frameDone <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end else if (bus.fillCount != '0) begin
            bus.advanceRead1 <= 1'b1;
            lines_consumed   <= lines_consumed + (ADDRESS_WIDTH + 1)'(1);
            state            <= S_DRAIN_GAP;
          end
        end

        S_DRAIN_GAP: state <= S_DRAIN;

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
